// File: rtl/mstr_pwrdn_seq_if.sv
// Handshake bundle between the power-down sequencer and its environment:
// request/emergency/power-good inputs plus the gate, done and fault outputs.
interface mstr_pwrdn_seq_if;
    logic       iTick_1ms;
    logic       iPwrdn_Req;
    logic       iLeak_Emergency_N;
    logic       iFan_Off_En;
    logic       iPWRGD_P12V_Nodex;
    logic       iPWRGD_P12V_AUX_FAN;
    logic       oNODEx_EN_gate;
    logic       oDevices_EN_gate;
    logic       oFAN_EN_gate;
    logic       oPwrdn_Done;
    logic       oNODEx_PWRDN_FLT;
    logic       oFAN_PWRDN_FLT;
    logic [3:0] oDBG_PWRDN_FSM_curr;

    modport master (
        output iTick_1ms, iPwrdn_Req, iLeak_Emergency_N, iFan_Off_En,
               iPWRGD_P12V_Nodex, iPWRGD_P12V_AUX_FAN,
        input  oNODEx_EN_gate, oDevices_EN_gate, oFAN_EN_gate, oPwrdn_Done,
               oNODEx_PWRDN_FLT, oFAN_PWRDN_FLT, oDBG_PWRDN_FSM_curr
    );

    modport slave (
        input  iTick_1ms, iPwrdn_Req, iLeak_Emergency_N, iFan_Off_En,
               iPWRGD_P12V_Nodex, iPWRGD_P12V_AUX_FAN,
        output oNODEx_EN_gate, oDevices_EN_gate, oFAN_EN_gate, oPwrdn_Done,
               oNODEx_PWRDN_FLT, oFAN_PWRDN_FLT, oDBG_PWRDN_FSM_curr
    );
endinterface

// File: rtl/mstr_pwrdn_seq.sv
// Master power-down sequencer: removes node, device and fan 12 V rails in
// reverse order with fixed delays and power-good decay timeouts.
module mstr_pwrdn_seq #(
    parameter int unsigned DLY_NODE_DEV_MS = 20,
    parameter int unsigned DLY_DEV_FAN_MS  = 150,
    parameter int unsigned PGOOD_TMO_MS    = 1000
) (
    input  logic                 iClk,
    input  logic                 iRst_n,
    mstr_pwrdn_seq_if.slave      seq_if
);

    typedef enum logic [3:0] {
        ST_IDLE     = 4'h9,
        ST_NODE_OFF = 4'h8,
        ST_NODE_DLY = 4'h6,
        ST_DEV_OFF  = 4'h4,
        ST_FAN_OFF  = 4'h2,
        ST_DONE     = 4'h0,
        ST_EMERG    = 4'he
    } state_e;

    localparam logic [15:0] NODE_DEV_N = 16'(DLY_NODE_DEV_MS);
    localparam logic [15:0] DEV_FAN_N  = 16'(DLY_DEV_FAN_MS);
    localparam logic [15:0] TMO_N      = 16'(PGOOD_TMO_MS);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        node_gate_q, node_gate_d;
    logic        dev_gate_q, dev_gate_d;
    logic        fan_gate_q, fan_gate_d;
    logic        done_q, done_d;
    logic        node_flt_q, node_flt_d;
    logic        fan_flt_q, fan_flt_d;

    // Next-state, delay counter and output-gate decode.
    always_comb begin
        state_d    = state_q;
        node_flt_d = node_flt_q;
        fan_flt_d  = fan_flt_q;

        if (!seq_if.iLeak_Emergency_N && (state_q != ST_EMERG)) begin
            state_d = ST_EMERG;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (seq_if.iPwrdn_Req) begin
                        state_d    = ST_NODE_OFF;
                        node_flt_d = 1'b1;
                        fan_flt_d  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                // Power-good low takes precedence over a coincident timeout.
                ST_NODE_OFF: begin
                    if (!seq_if.iPWRGD_P12V_Nodex) begin
                        state_d = ST_NODE_DLY;
                    end else if (cnt_q >= TMO_N) begin
                        state_d    = ST_NODE_DLY;
                        node_flt_d = 1'b0;
                    end else begin
                        state_d = ST_NODE_OFF;
                    end
                end
                ST_NODE_DLY: begin
                    if (cnt_q >= NODE_DEV_N) begin
                        state_d = ST_DEV_OFF;
                    end else begin
                        state_d = ST_NODE_DLY;
                    end
                end
                ST_DEV_OFF: begin
                    if (cnt_q >= DEV_FAN_N) begin
                        state_d = seq_if.iFan_Off_En ? ST_FAN_OFF : ST_DONE;
                    end else begin
                        state_d = ST_DEV_OFF;
                    end
                end
                ST_FAN_OFF: begin
                    if (!seq_if.iPWRGD_P12V_AUX_FAN) begin
                        state_d = ST_DONE;
                    end else if (cnt_q >= TMO_N) begin
                        state_d   = ST_DONE;
                        fan_flt_d = 1'b0;
                    end else begin
                        state_d = ST_FAN_OFF;
                    end
                end
                ST_DONE: begin
                    if (!seq_if.iPwrdn_Req) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
                ST_EMERG: state_d = ST_EMERG;
                default:  state_d = ST_IDLE;
            endcase
        end

        // A tick in the entry cycle is dropped because the counter clears.
        if (state_d != state_q) begin
            cnt_d = 16'h0000;
        end else if (seq_if.iTick_1ms && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'h0001;
        end else begin
            cnt_d = cnt_q;
        end

        node_gate_d = 1'b1;
        dev_gate_d  = 1'b1;
        fan_gate_d  = 1'b1;
        case (state_d)
            ST_IDLE: begin
                node_gate_d = 1'b1;
                dev_gate_d  = 1'b1;
                fan_gate_d  = 1'b1;
            end
            ST_NODE_OFF, ST_NODE_DLY: begin
                node_gate_d = 1'b0;
            end
            ST_DEV_OFF: begin
                node_gate_d = 1'b0;
                dev_gate_d  = 1'b0;
            end
            ST_FAN_OFF: begin
                node_gate_d = 1'b0;
                dev_gate_d  = 1'b0;
                fan_gate_d  = 1'b0;
            end
            // Fan gate in DONE remembers whether FAN_OFF was visited.
            ST_DONE: begin
                node_gate_d = 1'b0;
                dev_gate_d  = 1'b0;
                fan_gate_d  = fan_gate_q;
            end
            ST_EMERG: begin
                node_gate_d = 1'b0;
                dev_gate_d  = 1'b0;
                fan_gate_d  = 1'b1;
            end
            default: begin
                node_gate_d = 1'b1;
                dev_gate_d  = 1'b1;
                fan_gate_d  = 1'b1;
            end
        endcase

        done_d = (state_d == ST_DONE) || (state_d == ST_EMERG);
    end

    // State, counter and all outputs registered; reset restores gates at once.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 16'h0000;
            node_gate_q <= 1'b1;
            dev_gate_q  <= 1'b1;
            fan_gate_q  <= 1'b1;
            done_q      <= 1'b0;
            node_flt_q  <= 1'b1;
            fan_flt_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            node_gate_q <= node_gate_d;
            dev_gate_q  <= dev_gate_d;
            fan_gate_q  <= fan_gate_d;
            done_q      <= done_d;
            node_flt_q  <= node_flt_d;
            fan_flt_q   <= fan_flt_d;
        end
    end

    assign seq_if.oNODEx_EN_gate      = node_gate_q;
    assign seq_if.oDevices_EN_gate    = dev_gate_q;
    assign seq_if.oFAN_EN_gate        = fan_gate_q;
    assign seq_if.oPwrdn_Done         = done_q;
    assign seq_if.oNODEx_PWRDN_FLT    = node_flt_q;
    assign seq_if.oFAN_PWRDN_FLT      = fan_flt_q;
    assign seq_if.oDBG_PWRDN_FSM_curr = state_q;

endmodule

// File: tb/tb_mstr_pwrdn_seq.sv
// Directed bench for mstr_pwrdn_seq: normal, stuck power-good, fan, emergency,
// request release and asynchronous reset scenarios.
module tb_mstr_pwrdn_seq;

    logic iClk;
    logic iRst_n;
    int   checks_cnt;
    int   errors_cnt;

    mstr_pwrdn_seq_if seq_if ();

    mstr_pwrdn_seq #(
        .DLY_NODE_DEV_MS (20),
        .DLY_DEV_FAN_MS  (150),
        .PGOOD_TMO_MS    (1000)
    ) dut (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .seq_if (seq_if)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic check_val(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks_cnt++;
        if (act !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge iClk);
        #1;
    endtask

    task automatic pulse();
        seq_if.iTick_1ms = 1'b1;
        cyc();
        seq_if.iTick_1ms = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            pulse();
            cyc();
            cyc();
            cyc();
        end
    endtask

    // Checks state plus the packed {node, dev, fan} gates and done.
    task automatic check_st(input string tag, input logic [3:0] st, input logic [2:0] gates, input logic done);
        check_val({tag, "_state"}, 16'(seq_if.oDBG_PWRDN_FSM_curr), 16'(st));
        check_val({tag, "_gates"}, 16'({seq_if.oNODEx_EN_gate, seq_if.oDevices_EN_gate,
                                         seq_if.oFAN_EN_gate}), 16'(gates));
        check_val({tag, "_done"}, 16'(seq_if.oPwrdn_Done), 16'(done));
    endtask

    task automatic check_flt(input string tag, input logic [1:0] flt);
        check_val(tag, 16'({seq_if.oNODEx_PWRDN_FLT, seq_if.oFAN_PWRDN_FLT}), 16'(flt));
    endtask

    initial begin
        checks_cnt = 0;
        errors_cnt = 0;
        iRst_n                     = 1'b0;
        seq_if.iTick_1ms           = 1'b0;
        seq_if.iPwrdn_Req          = 1'b0;
        seq_if.iLeak_Emergency_N   = 1'b1;
        seq_if.iFan_Off_En         = 1'b0;
        seq_if.iPWRGD_P12V_Nodex   = 1'b1;
        seq_if.iPWRGD_P12V_AUX_FAN = 1'b1;
        #23;
        check_st("reset", 4'h9, 3'b111, 1'b0);
        check_flt("reset_flt", 2'b11);
        iRst_n = 1'b1;
        cyc();
        cyc();
        check_st("idle", 4'h9, 3'b111, 1'b0);

        // 1: normal shutdown, fan stays on
        seq_if.iPwrdn_Req = 1'b1;
        cyc();
        check_st("t1_node_off", 4'h8, 3'b011, 1'b0);
        ticks(5);
        seq_if.iPWRGD_P12V_Nodex = 1'b0;
        cyc();
        check_st("t1_node_dly", 4'h6, 3'b011, 1'b0);
        ticks(19);
        pulse();
        check_st("t1_dly_edge", 4'h6, 3'b011, 1'b0);
        cyc();
        check_st("t1_dev_off", 4'h4, 3'b001, 1'b0);
        ticks(149);
        pulse();
        check_st("t1_dev_edge", 4'h4, 3'b001, 1'b0);
        cyc();
        check_st("t1_done", 4'h0, 3'b001, 1'b1);
        check_flt("t1_flt", 2'b11);
        seq_if.iPwrdn_Req = 1'b0;
        cyc();
        check_st("t1_idle", 4'h9, 3'b111, 1'b0);

        // 2: node power-good stuck high
        seq_if.iPWRGD_P12V_Nodex = 1'b1;
        seq_if.iPwrdn_Req = 1'b1;
        cyc();
        ticks(999);
        check_st("t2_wait", 4'h8, 3'b011, 1'b0);
        check_flt("t2_no_flt_yet", 2'b11);
        pulse();
        check_st("t2_tmo_edge", 4'h8, 3'b011, 1'b0);
        cyc();
        check_st("t2_node_dly", 4'h6, 3'b011, 1'b0);
        check_flt("t2_flt", 2'b01);
        ticks(20);
        check_st("t2_dev_off", 4'h4, 3'b001, 1'b0);

        // 5: request released mid-sequence still runs to DONE
        seq_if.iPwrdn_Req = 1'b0;
        ticks(149);
        pulse();
        cyc();
        check_st("t5_done", 4'h0, 3'b001, 1'b1);
        cyc();
        check_st("t5_idle", 4'h9, 3'b111, 1'b0);
        check_flt("t5_flt_kept", 2'b01);
        seq_if.iPWRGD_P12V_Nodex = 1'b0;
        seq_if.iFan_Off_En = 1'b1;
        seq_if.iPwrdn_Req = 1'b1;
        cyc();
        check_flt("t5_flt_clr", 2'b11);

        // 3: fan off with stuck fan power-good; node pg already low
        cyc();
        check_st("t3_node_dly", 4'h6, 3'b011, 1'b0);
        check_flt("t3_no_node_flt", 2'b11);
        ticks(20);
        ticks(149);
        pulse();
        cyc();
        check_st("t3_fan_off", 4'h2, 3'b000, 1'b0);
        ticks(999);
        check_flt("t3_no_fan_flt_yet", 2'b11);
        pulse();
        cyc();
        check_st("t3_done", 4'h0, 3'b000, 1'b1);
        check_flt("t3_fan_flt", 2'b10);
        seq_if.iPwrdn_Req = 1'b0;
        cyc();
        check_st("t3_idle", 4'h9, 3'b111, 1'b0);

        // 4: emergency in NODE_DLY is sticky until reset
        seq_if.iFan_Off_En = 1'b0;
        seq_if.iPwrdn_Req = 1'b1;
        cyc();
        cyc();
        check_st("t4_node_dly", 4'h6, 3'b011, 1'b0);
        seq_if.iLeak_Emergency_N = 1'b0;
        cyc();
        check_st("t4_emerg", 4'he, 3'b001, 1'b1);
        seq_if.iLeak_Emergency_N = 1'b1;
        seq_if.iPwrdn_Req = 1'b0;
        ticks(3);
        check_st("t4_sticky", 4'he, 3'b001, 1'b1);
        iRst_n = 1'b0;
        #2;
        check_st("t4_reset", 4'h9, 3'b111, 1'b0);
        iRst_n = 1'b1;
        cyc();

        // 6: asynchronous reset while in FAN_OFF
        seq_if.iFan_Off_En = 1'b1;
        seq_if.iPwrdn_Req = 1'b1;
        cyc();
        cyc();
        ticks(20);
        ticks(150);
        check_st("t6_fan_off", 4'h2, 3'b000, 1'b0);
        #2;
        iRst_n = 1'b0;
        #2;
        check_st("t6_reset", 4'h9, 3'b111, 1'b0);
        check_flt("t6_flt", 2'b11);
        iRst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule

// File: doc/mstr_pwrdn_seq.md
# mstr_pwrdn_seq

Master power-down sequencer. It is the shutdown counterpart of the master power-up sequencer: on a power-down request it removes the node, device and fan 12 V rails in reverse order, with fixed inter-rail delays and power-good decay checks. It also flags rails whose power-good fails to fall in time. Its outputs are active-high enable gates that the top level ANDs with the power-up sequencer's enables.

## Interface

Parameters:
- DLY_NODE_DEV_MS, 20: delay in ms from node power-good low (or timeout) to the device disable.
- DLY_DEV_FAN_MS, 150: delay in ms from the device disable to the fan disable.
- PGOOD_TMO_MS, 1000: maximum wait in ms for a power-good to decay.

Ports:
- iClk, in, 1: module clock, 2 MHz. Single clock domain.
- iRst_n, in, 1: asynchronous, active-low reset.
- iTick_1ms, in, 1: one-iClk-wide strobe every 1 ms, synchronous to iClk.
- iPwrdn_Req, in, 1: level request to power down (DC button off or RMC disable).
- iLeak_Emergency_N, in, 1: low means leakage detected; forces an immediate shutdown.
- iFan_Off_En, in, 1: 1 means the fan rail is also removed; 0 means the fan stays on.
- iPWRGD_P12V_Nodex, in, 1: node rail power-good.
- iPWRGD_P12V_AUX_FAN, in, 1: fan rail power-good.
- oNODEx_EN_gate, out, 1: gate for P12V_NODEx, N1 and N2 enables.
- oDevices_EN_gate, out, 1: gate for PWR_EN_Devices.
- oFAN_EN_gate, out, 1: gate for P12V_AUX_FAN_EN.
- oPwrdn_Done, out, 1: sequence complete.
- oNODEx_PWRDN_FLT, out, 1: active-low; node power-good did not decay in time.
- oFAN_PWRDN_FLT, out, 1: active-low; fan power-good did not decay in time.
- oDBG_PWRDN_FSM_curr, out, 4: current state code.

## Operation

Reset values:
- All three gates = 1.
- oPwrdn_Done = 0.
- Both fault outputs = 1.
- State = IDLE.
- Delay counter = 0.

Delay counter:
- 16-bit, cleared on every state entry.
- Increments on each iTick_1ms and saturates at 0xFFFF.
- "Expired(N)" means counter ≥ N.

States (code: behaviour):
- 4'h9 IDLE: all gates = 1, Done = 0. On iPwrdn_Req = 1 go to NODE_OFF.
- 4'h8 NODE_OFF: oNODEx_EN_gate = 0. Leave to NODE_DLY when iPWRGD_P12V_Nodex = 0 or Expired(PGOOD_TMO_MS). On timeout with power-good still high, latch oNODEx_PWRDN_FLT = 0.
- 4'h6 NODE_DLY: on Expired(DLY_NODE_DEV_MS) go to DEV_OFF.
- 4'h4 DEV_OFF: oDevices_EN_gate = 0. On Expired(DLY_DEV_FAN_MS), go to FAN_OFF if iFan_Off_En = 1, otherwise to DONE.
- 4'h2 FAN_OFF: oFAN_EN_gate = 0. Leave to DONE when iPWRGD_P12V_AUX_FAN = 0 or Expired(PGOOD_TMO_MS). On timeout with power-good still high, latch oFAN_PWRDN_FLT = 0.
- 4'h0 DONE: oPwrdn_Done = 1.
  - When iPwrdn_Req = 0: all gates return to 1, Done returns to 0, go to IDLE.
  - Fan gate in this case returns to 1 as well.
- 4'he EMERG: entered from any state except EMERG when iLeak_Emergency_N = 0.
  - Node and device gates = 0 immediately; fan gate = 1 (coolant pump and fans keep running).
  - Done = 1. Sticky; only reset leaves EMERG.

Rules:
- Gates only ever go low in order node, then devices, then fan. No gate is re-enabled before DONE exits.
- iPwrdn_Req falling mid-sequence does not abort: the sequence runs to DONE, then returns to IDLE on the next cycle if the request is still low.
- Fault latches are cleared only by reset, or on the IDLE to NODE_OFF transition (new sequence).
- Power-good already low at NODE_OFF or FAN_OFF entry exits the next cycle with no fault.
- A delay parameter of 0 means the state exits the cycle after entry.

## Timing

- State register, gates, Done and faults are all registered. An output changes one iClk after the causing input or expiry condition.
- Request to node gate low: 1 cycle.
- Emergency to gates low: 1 cycle, from any state, with priority over every other transition.
- Expiry is evaluated against the registered counter. State exit happens one cycle after the tick that reaches N.
- iTick_1ms arriving in the same cycle as a state entry is ignored (the counter clears); count starts at the next tick.
- Timeout and power-good falling in the same cycle: power-good wins, so no fault is recorded.
- Reset mid-sequence: all gates return to 1 asynchronously.

## Test plan

1. Normal shutdown, iFan_Off_En = 0:
   - Stimulus: assert iPwrdn_Req; node power-good drops 5 ms later.
   - Response: node gate low at +1 cycle; devices gate low about 20 ms after power-good drops; Done about 150 ms later; fan gate stays 1; faults stay 1; state codes 9 → 8 → 6 → 4 → 0.
2. Node power-good stuck high:
   - Response: after 1000 ticks, oNODEx_PWRDN_FLT = 0 and the sequence continues to DEV_OFF.
3. Fan off with stuck fan power-good:
   - Stimulus: iFan_Off_En = 1, iPWRGD_P12V_AUX_FAN held high.
   - Response: fan gate low after the 150 ms delay; oFAN_PWRDN_FLT = 0 at +1000 ms; Done = 1.
4. Emergency:
   - Stimulus: iLeak_Emergency_N = 0 while in NODE_DLY.
   - Response: next cycle, state 4'he, node and device gates 0, fan gate 1, Done 1. Releasing the emergency input does not leave the state; only iRst_n does.
5. Request release:
   - Stimulus: drop iPwrdn_Req in DEV_OFF.
   - Response: sequence still reaches DONE, then returns to IDLE with all gates 1 one cycle later. A new request clears both fault latches.
6. Reset mid-sequence:
   - Stimulus: iRst_n low in FAN_OFF.
   - Response: all gates 1, Done 0, state 4'h9, faults 1, without waiting for a clock edge.
